// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: opcodes, FSM states, flag bundle.
// Used by alu_core and alu_seq (MUL support behind ALU_SEQ_MUL_EN).
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_OR  = 4'b0011,
      OP_XOR = 4'b0100,
      OP_NOT = 4'b0101,
      OP_SLL = 4'b1000,
      OP_SRL = 4'b1001,
      OP_SRA = 4'b1010,
      OP_MUL = 4'b1011
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
      logic illegal;
   } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath for all single-cycle opcodes.
// MUL and undefined opcodes report illegal here.
module alu_core
   import alu_seq_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   op,
   output logic [N-1:0] res,
   output alu_flags_t   flags
);

   localparam int SW = $clog2(N);

   logic [SW-1:0] sh;
   logic [N:0]    sum;
   logic [N:0]    dif;
   logic [N:0]    sl;
   logic [N:0]    sr;
   logic [N:0]    sra;

   assign sh  = b[SW-1:0];
   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};
   // extra bit beyond the word catches the last bit shifted out
   assign sl  = {1'b0, a} << sh;
   assign sr  = {a, 1'b0} >> sh;
   assign sra = $unsigned($signed({a, 1'b0}) >>> sh);

   // opcode decode, then flags derived from the result
   always_comb begin
      res   = '0;
      flags = '0;
      unique case (1'b1)
         op == OP_ADD: begin
            res            = sum[N-1:0];
            flags.carry    = sum[N];
            flags.overflow = (a[N-1] == b[N-1]) &&
                             (sum[N-1] != a[N-1]);
         end
         op == OP_SUB: begin
            res            = dif[N-1:0];
            flags.carry    = ~dif[N];
            flags.overflow = (a[N-1] != b[N-1]) &&
                             (dif[N-1] != a[N-1]);
         end
         op == OP_AND: res = a & b;
         op == OP_OR:  res = a | b;
         op == OP_XOR: res = a ^ b;
         op == OP_NOT: res = ~a;
         op == OP_SLL: begin
            res         = sl[N-1:0];
            flags.carry = sl[N];
         end
         op == OP_SRL: begin
            res         = sr[N:1];
            flags.carry = sr[0];
         end
         op == OP_SRA: begin
            res         = sra[N:1];
            flags.carry = sra[0];
         end
         default: flags.illegal = 1'b1;
      endcase
      flags.zero     = (res == '0);
      flags.negative = res[N-1];
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready in and out.
// Define ALU_SEQ_MUL_EN for the iterative shift-add multiplier.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         zero,
   output logic         negative,
   output logic         carry,
   output logic         overflow,
   output logic         illegal
);

   logic [N-1:0] cres;
   alu_flags_t   cflg;

   logic         accept;
   logic         load;
   logic [N-1:0] ld_c;
   alu_flags_t   ld_f;

   logic         ov_q;
   logic [N-1:0] c_q;
   alu_flags_t   f_q;

   alu_core #(.N(N)) u_core (
      .a     (a),
      .b     (b),
      .op    (op),
      .res   (cres),
      .flags (cflg)
   );

   assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(N);

   alu_state_e     state;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [2*N-1:0] pp_sum;
   logic           is_mul;
   logic           mul_done;

   assign is_mul   = (op == OP_MUL);
   assign mul_done = (state == ST_MUL) && (cnt == CW'(N - 1));
   assign pp_sum   = acc + (mplier[0] ? mcand : '0);
   assign in_ready = (state == ST_IDLE) && (!ov_q || out_ready);

   // FSM and shift-add datapath, one partial product per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else begin
         unique case (1'b1)
            state == ST_IDLE: begin
               if (accept && is_mul) begin
                  state  <= ST_MUL;
                  cnt    <= '0;
                  acc    <= '0;
                  mcand  <= {{N{1'b0}}, a};
                  mplier <= b;
               end
            end
            state == ST_MUL: begin
               acc    <= pp_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (mul_done) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // pick the completing result: single-cycle op or finished product
   always_comb begin
      load = (accept && !is_mul) || mul_done;
      ld_c = cres;
      ld_f = cflg;
      if (mul_done) begin
         ld_c          = pp_sum[N-1:0];
         ld_f          = '0;
         ld_f.carry    = |pp_sum[2*N-1:N];
         ld_f.zero     = (pp_sum[N-1:0] == '0);
         ld_f.negative = pp_sum[N-1];
      end
   end
`else
   assign in_ready = !ov_q || out_ready;

   // every opcode completes in the accepting cycle
   always_comb begin
      load = accept;
      ld_c = cres;
      ld_f = cflg;
   end
`endif

   // output register: load on completion, clear valid on transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q <= 1'b0;
         c_q  <= '0;
         f_q  <= '{zero: 1'b1, default: 1'b0};
      end else if (load) begin
         ov_q <= 1'b1;
         c_q  <= ld_c;
         f_q  <= ld_f;
      end else if (out_ready) begin
         ov_q <= 1'b0;
      end
   end

   assign out_valid = ov_q;
   assign c         = c_q;
   assign zero      = f_q.zero;
   assign negative  = f_q.negative;
   assign carry     = f_q.carry;
   assign overflow  = f_q.overflow;
   assign illegal   = f_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors checked against a queue-based model.
// Honours ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;

   localparam int N = 4;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MULEN = 1'b1;
`else
   localparam bit MULEN = 1'b0;
`endif

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2;
   localparam logic [3:0] OR_ = 4'd3, XOR_ = 4'd4, NOT_ = 4'd5;
   localparam logic [3:0] SLL = 4'd8, SRL = 4'd9, SRA = 4'd10;
   localparam logic [3:0] MUL = 4'd11;

   typedef struct {
      int c;
      int z;
      int n;
      int cy;
      int ov;
      int il;
      int due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [N-1:0] c;
   logic         zero, negative, carry, overflow, illegal;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   busy_until = 0;
   bit   chk_en = 1'b0;
   exp_t q[$];

   alu_seq #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .zero      (zero),
      .negative  (negative),
      .carry     (carry),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d t=%0t",
                  name, act, req, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= 8) ? v - 16 : v;
   endfunction

   // reference behaviour from the arithmetic definition, N = 4
   function automatic exp_t model(input int o, input int x, input int y);
      exp_t e;
      int   s, r;
      e = '{default: 0};
      s = y % 4;
      case (o)
         0: begin
            e.c  = (x + y) % 16;
            e.cy = (x + y) >= 16;
            r    = sgn(x) + sgn(y);
            e.ov = (r > 7) || (r < -8);
         end
         1: begin
            e.c  = (x - y + 16) % 16;
            e.cy = x >= y;
            r    = sgn(x) - sgn(y);
            e.ov = (r > 7) || (r < -8);
         end
         2: e.c = x & y;
         3: e.c = x | y;
         4: e.c = x ^ y;
         5: e.c = 15 - x;
         8: begin
            e.c  = (x << s) % 16;
            e.cy = (s == 0) ? 0 : (x >> (4 - s)) & 1;
         end
         9: begin
            e.c  = x >> s;
            e.cy = (s == 0) ? 0 : (x >> (s - 1)) & 1;
         end
         10: begin
            e.c  = (sgn(x) >>> s) & 15;
            e.cy = (s == 0) ? 0 : (x >> (s - 1)) & 1;
         end
         11: begin
            if (MULEN) begin
               e.c  = (x * y) % 16;
               e.cy = (x * y) >= 16;
            end else begin
               e.il = 1;
            end
         end
         default: e.il = 1;
      endcase
      e.z = (e.c == 0);
      e.n = (e.c >= 8);
      return e;
   endfunction

   // per-cycle compare against the model queue
   always @(negedge clk) begin
      bit   vm, rm;
      exp_t e;
      int   lat;
      cyc++;
      if (!rst_n) begin
         q.delete();
         busy_until = 0;
      end else if (chk_en) begin
         vm = (q.size() > 0) && (cyc >= q[0].due);
         rm = (cyc >= busy_until) && (!vm || out_ready);
         chk("out_valid", int'(out_valid), int'(vm));
         chk("in_ready", int'(in_ready), int'(rm));
         if (vm && out_valid) begin
            chk("c", int'(c), q[0].c);
            chk("zero", int'(zero), q[0].z);
            chk("negative", int'(negative), q[0].n);
            chk("carry", int'(carry), q[0].cy);
            chk("overflow", int'(overflow), q[0].ov);
            chk("illegal", int'(illegal), q[0].il);
         end
         if (vm && out_ready) void'(q.pop_front());
         if (in_valid && in_ready) begin
            e   = model(int'(op), int'(a), int'(b));
            lat = (MULEN && op == MUL) ? N : 1;
            e.due = cyc + lat;
            if (lat > 1) busy_until = cyc + lat;
            q.push_back(e);
         end
      end
   end

   // present one operation and hold it until accepted
   task automatic send(input logic [3:0] o, input int x, input int y);
      bit ok;
      in_valid = 1'b1;
      op = o;
      a  = N'(x);
      b  = N'(y);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (!ok) out_ready = 1'b1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      a  = N'($urandom);
      b  = N'($urandom);
      op = 4'($urandom);
   endtask

   typedef struct {
      logic [3:0] o;
      int         x;
      int         y;
   } vec_t;

   vec_t vecs[14] = '{
      '{AND_, 12, 10}, '{OR_, 12, 10}, '{XOR_, 12, 10},
      '{NOT_, 12, 0}, '{SRL, 9, 3}, '{SRA, 5, 1},
      '{SLL, 7, 0}, '{ADD, 7, 1}, '{SUB, 8, 1},
      '{4'd6, 3, 3}, '{4'd15, 9, 9}, '{MUL, 3, 5},
      '{MUL, 15, 15}, '{SRL, 8, 0}
   };

   initial begin
      exp_t e;
      int   n;
      logic [N-1:0] hold_c;

      // model pinned to hand-computed values
      e = model(0, 12, 10);
      chk("pin_add_c", e.c, 6);
      chk("pin_add_ov", e.ov, 1);
      e = model(1, 10, 12);
      chk("pin_sub_c", e.c, 14);
      chk("pin_sub_cy", e.cy, 0);
      e = model(10, 12, 2);
      chk("pin_sra_c", e.c, 15);
      e = model(8, 13, 1);
      chk("pin_sll_cy", e.cy, 1);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_c", int'(c), 0);
      chk("rst_zero", int'(zero), 1);
      chk("rst_flags", int'({negative, carry, overflow, illegal}), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);

      send(ADD, 12, 10);
      chk("add_c", int'(c), 6);
      chk("add_cv", int'({carry, overflow, zero, negative}), 4'b1100);
      send(SUB, 12, 10);
      chk("sub1_c", int'(c), 2);
      send(SUB, 10, 12);
      chk("sub2_c", int'(c), 14);
      chk("sub2_cn", int'({carry, negative}), 2'b01);
      send(SRA, 12, 2);
      chk("sra_c", int'(c), 15);
      send(SLL, 13, 1);
      chk("sll_c", int'(c), 10);
      chk("sll_cy", int'(carry), 1);

      // multiply latency and result
      send(MUL, 13, 11);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mul_lat", n, MULEN ? 4 : 0);
      chk("mul_c", int'(c), MULEN ? 15 : 0);
      chk("mul_cy", int'(carry), MULEN ? 1 : 0);
      chk("mul_il", int'(illegal), MULEN ? 0 : 1);

      // backpressure then transfer plus accept in one cycle
      send(ADD, 3, 4);
      out_ready = 1'b0;
      hold_c = c;
      in_valid = 1'b1;
      op = ADD;
      a  = 4'd1;
      b  = 4'd1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("bp_hold_c", int'(c), int'(hold_c));
         chk("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_c", int'(c), 2);
      chk("bp_next_v", int'(out_valid), 1);

      // reset in the middle of a multiply
      send(MUL, 13, 11);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", int'(out_valid), 0);
      chk("mrst_zero", int'(zero), 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("mrst_noresult", int'(out_valid), 0);
      send(ADD, 3, 1);
      chk("mrst_add_c", int'(c), 4);

      // vector table with intermittent backpressure
      foreach (vecs[i]) begin
         out_ready = (i % 3) != 1;
         send(vecs[i].o, vecs[i].x, vecs[i].y);
      end
      out_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with valid/ready handshakes on input and output, a registered flag set, and an optional iterative multiplier. It is the sequential successor to the combinational parametrised ALU. It sits between an operand source and a result consumer, and it tolerates backpressure without losing or duplicating results.

## Interface
- `N`, default 4: operand/result width, N ≥ 2; shift amount is `b[$clog2(N)-1:0]`
- `clk`, input, 1: sole clock, rising edge
- `rst_n`, input, 1: asynchronous, active-low reset
- `in_valid`, input, 1: operands and opcode present
- `in_ready`, output, 1: block accepts on `in_valid && in_ready` at a rising edge
- `a`, input, N: operand A
- `b`, input, N: operand B
- `op`, input, 4: opcode
- `out_valid`, output, 1: `c` and flags hold a result
- `out_ready`, input, 1: consumer takes result on `out_valid && out_ready`
- `c`, output, N: result
- `zero`, `negative`, `carry`, `overflow`, output, 1 each: flags for `c`
- `illegal`, output, 1: current result came from an undefined opcode

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT a
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - 1011 MUL
- All other opcodes are illegal: `c` = 0, `zero` = 1, `negative`/`carry`/`overflow` = 0, `illegal` = 1.
- `zero` = (c == 0).
- `negative` = c[N-1].
- ADD:
  - c = (a+b) mod 2^N
  - `carry` = bit N of the (N+1)-bit sum
  - `overflow` = signed overflow
- SUB:
  - c = (a−b) mod 2^N
  - `carry` = 1 iff a ≥ b unsigned (no borrow)
  - `overflow` = signed overflow
- Logic ops: `carry` = `overflow` = 0.
- Shifts:
  - `carry` = last bit shifted out; 0 if the shift amount is 0
  - `overflow` = 0
  - SRA replicates a[N-1]
- MUL:
  - Unsigned, iterative shift-add, one partial product per cycle.
  - c = low N bits of the 2N-bit product.
  - `carry` = 1 iff the high N bits ≠ 0.
  - `overflow` = 0.
- FSM states:
  - IDLE: accepting. A single-cycle op goes to IDLE with the result loaded. MUL goes to MUL with the counter cleared.
  - MUL: counter 0..N-1. At count N-1, load the result and go to IDLE.
- Output register:
  - Loaded only when a result completes.
  - Held stable while `out_valid && !out_ready`.
  - `out_valid` clears on the transfer unless a new result loads in the same cycle.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready).
- Operands are captured at acceptance; changes to `a`, `b`, `op` afterwards have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0
  - `out_valid` = 0, `c` = 0, `illegal` = 0
  - `zero` = 1; `negative`, `carry`, `overflow` = 0
  - `in_ready` = 1 one cycle after `rst_n` rises
- Single-cycle ops: accepted at edge k, so `out_valid` is 1 after edge k.
  - Throughput is 1 per cycle while `out_ready` = 1.
- MUL: accepted at edge k, so `out_valid` is 1 after edge k+N.
  - `in_ready` = 0 during edges k+1..k+N.
- A simultaneous output transfer and new acceptance in the same cycle is legal. The new result replaces the old one with no bubble.
- Reset asserted mid-MUL aborts the multiply. No result is produced and the partial product is discarded.

## Configuration
- `ALU_SEQ_MUL_EN` defined: opcode 1011 is MUL as above, and the MUL state, counter and product registers are present.
- `ALU_SEQ_MUL_EN` undefined:
  - 1011 is illegal and the MUL datapath is absent.
  - All opcodes have 1-cycle latency.
  - `in_ready` = !out_valid || out_ready.

## Structure
- Package `alu_seq_pkg`:
  - opcode enum `alu_op_e` (4-bit)
  - FSM enum `alu_state_e`
  - flag struct `alu_flags_t` {zero, negative, carry, overflow, illegal}
- Sub-module `alu_core`, combinational, parameter `N`:
  - inputs `a`, `b`, `op`
  - outputs result and `alu_flags_t` for all single-cycle opcodes
- `alu_seq` instantiates `alu_core` and holds the FSM, MUL datapath and output register.

## Test plan
All scenarios use N=4.
- ADD, a=1100 b=1010, `out_ready`=1 → next cycle c=0110, carry=1, overflow=1, zero=0, negative=0.
- SUB, a=1100 b=1010 → c=0010, carry=1, overflow=0; then SUB a=1010 b=1100 → c=1110, carry=0, negative=1.
- SRA, a=1100 b=0010 → c=1111, carry=0, negative=1; SLL a=1101 b=0001 → c=1010, carry=1.
- MUL, a=1101 b=1011 (with `ALU_SEQ_MUL_EN`) → `in_ready`=0 for 4 cycles, `out_valid` after edge k+4, c=1111, carry=1, negative=1. Without the macro, the same stimulus gives illegal=1, c=0, zero=1.
- Backpressure: ADD result pending with `out_ready`=0 for 3 cycles → c and flags stable, `in_ready`=0. Raising `out_ready` with a queued ADD a=0001 b=0001 → transfer plus accept in one cycle, next c=0010.
- `rst_n` pulsed low 2 cycles into a MUL → `out_valid`=0, zero=1, no result after release. A following ADD a=0011 b=0001 → c=0100.
